// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage: FSM states, access sizes, opcodes.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational store byte-enable/data replication and load extract/extend.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_shift,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_shift,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Reserved size 2'b10 falls into the word case.
  always_comb begin
    st_be    = 4'hF;
    st_wdata = st_data;
    case (st_size)
      SZ_B: begin
        st_be    = 4'b0001 << st_shift;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_be    = 4'b0011 << st_shift;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = ld_rdata[{ld_shift, 3'b000} +: 8];
    half_sel = ld_rdata[15:0];
    case (ld_shift)
      2'd1:    half_sel = ld_rdata[23:8];
      2'd2:    half_sel = ld_rdata[31:16];
      2'd3:    half_sel = {8'h00, ld_rdata[31:24]};
      default: half_sel = ld_rdata[15:0];
    endcase
  end

  always_comb begin
    ld_data = ld_rdata;
    case (ld_size)
      SZ_B: ld_data = ld_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H: ld_data = ld_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers EX results and runs the data-memory req/gnt/rvalid handshake.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_stall,
  input  logic        ex_valid,
  input  logic [6:0]  opcode_EX,
  input  logic [31:0] res_EX,
  input  logic [31:0] x2_EX,
  input  logic [1:0]  ldsz,
  input  logic [1:0]  ldshift,
  input  logic        ld_unsigned,
  input  logic [4:0]  rd_EX,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] res_MEM,
  output logic [4:0]  rd_MEM,
  output logic        stall_req,
  output logic        trap_MEM
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  mem_state_t  state, state_nxt;
  logic [7:0]  cnt;
  logic        capture, is_mem, timed_out;
  logic [1:0]  size_q, shift_q;
  logic        uns_q;
  logic [4:0]  rd_q;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  lsu_align u_align (
    .st_size     (ldsz),
    .st_shift    (ldshift),
    .st_data     (x2_EX),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_size     (size_q),
    .ld_shift    (shift_q),
    .ld_unsigned (uns_q),
    .ld_rdata    (dmem_rdata),
    .ld_data     (ld_data)
  );

  assign capture   = ex_valid && !ext_stall;
  assign is_mem    = (opcode_EX == OP_LOAD) || (opcode_EX == OP_STORE);
  assign dmem_req  = (state == REQ);
  assign stall_req = (state == REQ) || (state == WAIT && !dmem_rvalid);

  // A request is never withdrawn, so REQ/WAIT ignore ext_stall entirely.
  always_comb begin
    state_nxt = state;
    timed_out = 1'b0;
    case (state)
      IDLE: if (capture && is_mem) state_nxt = REQ;
      REQ: begin
        if (dmem_gnt) begin
          state_nxt = dmem_we ? IDLE : WAIT;
        end else if (cnt == TO_LAST) begin
          state_nxt = IDLE;
          timed_out = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_nxt = IDLE;
        end else if (cnt == TO_LAST) begin
          state_nxt = IDLE;
          timed_out = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      res_MEM    <= 32'd0;
      rd_MEM     <= 5'd0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
      trap_MEM   <= 1'b0;
      size_q     <= 2'd0;
      shift_q    <= 2'd0;
      uns_q      <= 1'b0;
      rd_q       <= 5'd0;
    end else begin
      state    <= state_nxt;
      trap_MEM <= timed_out;
      cnt      <= (state_nxt == state && state != IDLE) ? cnt + 8'd1 : 8'd0;

      if (state == IDLE && capture) begin
        if (is_mem) begin
          dmem_we    <= (opcode_EX == OP_STORE);
          dmem_addr  <= {res_EX[31:2], 2'b00};
          dmem_be    <= st_be;
          dmem_wdata <= st_wdata;
          size_q     <= ldsz;
          shift_q    <= ldshift;
          uns_q      <= ld_unsigned;
          rd_q       <= rd_EX;
          rd_MEM     <= 5'd0;
        end else begin
          res_MEM <= res_EX;
          rd_MEM  <= (opcode_EX == OP_BRANCH) ? 5'd0 : rd_EX;
        end
      end

      if (state == WAIT && dmem_rvalid) begin
        res_MEM <= ld_data;
        rd_MEM  <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic vs. an arithmetic model.
module tb_mem_stage;

  localparam logic [6:0] OP_ADD    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset, ext_stall, ex_valid, ld_unsigned;
  logic [6:0]  opcode_EX;
  logic [31:0] res_EX, x2_EX, dmem_rdata;
  logic [1:0]  ldsz, ldshift;
  logic [4:0]  rd_EX;
  logic        dmem_gnt, dmem_rvalid;
  logic        dmem_req, dmem_we, stall_req, trap_MEM;
  logic [31:0] dmem_addr, dmem_wdata, res_MEM;
  logic [3:0]  dmem_be;
  logic [4:0]  rd_MEM;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .ex_valid(ex_valid),
    .opcode_EX(opcode_EX), .res_EX(res_EX), .x2_EX(x2_EX), .ldsz(ldsz),
    .ldshift(ldshift), .ld_unsigned(ld_unsigned), .rd_EX(rd_EX),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .res_MEM(res_MEM),
    .rd_MEM(rd_MEM), .stall_req(stall_req), .trap_MEM(trap_MEM)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one instruction in EX for a single edge.
  task automatic applyStimulus(input logic [6:0] op, input logic [31:0] res, input logic [31:0] x2,
                               input logic [1:0] sz, input logic [1:0] sh, input logic uns,
                               input logic [4:0] rd);
    ex_valid = 1'b1; opcode_EX = op; res_EX = res; x2_EX = x2;
    ldsz = sz; ldshift = sh; ld_unsigned = uns; rd_EX = rd;
    cycle();
    ex_valid = 1'b0;
  endtask

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] sh);
    int nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (nbytes == 4) return 4'hF;
    return 4'((((1 << nbytes) - 1) << sh) & 15);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] x2);
    if (sz == 2'd0) return (x2 & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (x2 & 32'hFFFF) * 32'h00010001;
    return x2;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [1:0] sh,
                                             input logic uns, input logic [31:0] rdata);
    logic [31:0] d = rdata >> (8 * sh);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = d & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
      return v;
    end
    if (sz == 2'd1) begin
      v = d & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
      return v;
    end
    return rdata;
  endfunction

  initial begin
    logic [31:0] exp_res;
    logic [4:0]  exp_rd;
    reset = 1'b1; ext_stall = 1'b0; ex_valid = 1'b0; opcode_EX = 7'd0;
    res_EX = 32'd0; x2_EX = 32'd0; ldsz = 2'd0; ldshift = 2'd0; ld_unsigned = 1'b0;
    rd_EX = 5'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    cycle(); cycle();
    checkOutput("rst_res", res_MEM, 32'd0);
    checkOutput("rst_rd", 32'(rd_MEM), 32'd0);
    checkOutput("rst_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_we", 32'(dmem_we), 32'd0);
    checkOutput("rst_addr", dmem_addr, 32'd0);
    checkOutput("rst_be", 32'(dmem_be), 32'd0);
    checkOutput("rst_wdata", dmem_wdata, 32'd0);
    checkOutput("rst_trap", 32'(trap_MEM), 32'd0);
    checkOutput("rst_stall", 32'(stall_req), 32'd0);
    reset = 1'b0;

    $display("[TB] ADD passthrough");
    ex_valid = 1'b1;
    checkOutput("add_stall_pre", 32'(stall_req), 32'd0);
    applyStimulus(OP_ADD, 32'h1234, 32'h0, 2'd0, 2'd0, 1'b0, 5'd5);
    checkOutput("add_res", res_MEM, 32'h1234);
    checkOutput("add_rd", 32'(rd_MEM), 32'd5);
    checkOutput("add_stall", 32'(stall_req), 32'd0);

    $display("[TB] SB immediate grant");
    applyStimulus(OP_STORE, 32'h100, 32'hAB, 2'd0, 2'd2, 1'b0, 5'd9);
    checkOutput("sb_req", 32'(dmem_req), 32'd1);
    checkOutput("sb_we", 32'(dmem_we), 32'd1);
    checkOutput("sb_addr", dmem_addr, 32'h100);
    checkOutput("sb_be", 32'(dmem_be), 32'h4);
    checkOutput("sb_wdata", dmem_wdata, 32'hABABABAB);
    checkOutput("sb_stall", 32'(stall_req), 32'd1);
    checkOutput("sb_rd", 32'(rd_MEM), 32'd0);
    dmem_gnt = 1'b1;
    cycle();
    dmem_gnt = 1'b0;
    checkOutput("sb_done_stall", 32'(stall_req), 32'd0);
    checkOutput("sb_done_req", 32'(dmem_req), 32'd0);
    checkOutput("sb_done_res", res_MEM, 32'h1234);

    $display("[TB] LB signed, late grant");
    applyStimulus(OP_LOAD, 32'h200, 32'h0, 2'd0, 2'd3, 1'b0, 5'd6);
    checkOutput("lb_req0", 32'(dmem_req), 32'd1);
    cycle();
    checkOutput("lb_req1", 32'(dmem_req), 32'd1);
    checkOutput("lb_stall1", 32'(stall_req), 32'd1);
    dmem_gnt = 1'b1;
    cycle();
    dmem_gnt = 1'b0;
    checkOutput("lb_wait_req", 32'(dmem_req), 32'd0);
    checkOutput("lb_wait_stall", 32'(stall_req), 32'd1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80000000;
    #1;
    checkOutput("lb_rv_stall", 32'(stall_req), 32'd0);
    cycle();
    dmem_rvalid = 1'b0;
    checkOutput("lb_res", res_MEM, 32'hFFFFFF80);
    checkOutput("lb_rd", 32'(rd_MEM), 32'd6);

    $display("[TB] LHU with rvalid coincident to grant");
    applyStimulus(OP_LOAD, 32'h204, 32'h0, 2'd1, 2'd2, 1'b1, 5'd7);
    checkOutput("lhu_rd_clr", 32'(rd_MEM), 32'd0);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    cycle();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    cycle();
    checkOutput("lhu_still_wait", 32'(stall_req), 32'd1);
    checkOutput("lhu_no_early", 32'(rd_MEM), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80000000;
    cycle();
    dmem_rvalid = 1'b0;
    checkOutput("lhu_res", res_MEM, 32'h00008000);
    checkOutput("lhu_rd", 32'(rd_MEM), 32'd7);

    $display("[TB] LW timeout");
    applyStimulus(OP_LOAD, 32'h300, 32'h0, 2'd3, 2'd0, 1'b0, 5'd8);
    dmem_gnt = 1'b1;
    cycle();
    dmem_gnt = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checkOutput($sformatf("to_trap_early%0d", i), 32'(trap_MEM), 32'd0);
      checkOutput($sformatf("to_stall%0d", i), 32'(stall_req), 32'd1);
    end
    cycle();
    checkOutput("to_trap", 32'(trap_MEM), 32'd1);
    checkOutput("to_rd", 32'(rd_MEM), 32'd0);
    checkOutput("to_stall_idle", 32'(stall_req), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    cycle();
    dmem_rvalid = 1'b0;
    checkOutput("to_trap_pulse", 32'(trap_MEM), 32'd0);
    checkOutput("to_stray_res", res_MEM, 32'h00008000);
    checkOutput("to_stray_rd", 32'(rd_MEM), 32'd0);

    $display("[TB] ext_stall behaviour");
    ext_stall = 1'b1;
    applyStimulus(OP_ADD, 32'h5555, 32'h0, 2'd0, 2'd0, 1'b0, 5'd3);
    checkOutput("xs_idle_hold", res_MEM, 32'h00008000);
    checkOutput("xs_idle_req", 32'(dmem_req), 32'd0);
    ext_stall = 1'b0;
    applyStimulus(OP_LOAD, 32'h400, 32'h0, 2'd3, 2'd0, 1'b0, 5'd12);
    ext_stall = 1'b1; dmem_gnt = 1'b1;
    cycle();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    cycle();
    dmem_rvalid = 1'b0; ext_stall = 1'b0;
    checkOutput("xs_lw_res", res_MEM, 32'hCAFEF00D);
    checkOutput("xs_lw_rd", 32'(rd_MEM), 32'd12);

    $display("[TB] reset in REQ");
    applyStimulus(OP_STORE, 32'h508, 32'h77, 2'd1, 2'd0, 1'b0, 5'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkOutput("mr_req", 32'(dmem_req), 32'd0);
    checkOutput("mr_stall", 32'(stall_req), 32'd0);
    checkOutput("mr_res", res_MEM, 32'd0);
    checkOutput("mr_rd", 32'(rd_MEM), 32'd0);
    checkOutput("mr_addr", dmem_addr, 32'd0);
    checkOutput("mr_be", 32'(dmem_be), 32'd0);
    checkOutput("mr_trap", 32'(trap_MEM), 32'd0);

    $display("[TB] randomized traffic");
    exp_res = 32'd0;
    exp_rd  = 5'd0;
    for (int t = 0; t < 60; t++) begin
      int kind = $urandom_range(0, 3);
      logic [31:0] r  = $urandom;
      logic [31:0] x2 = $urandom;
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [1:0]  sh = 2'($urandom_range(0, 3));
      logic        un = 1'($urandom_range(0, 1));
      logic [4:0]  rd = 5'($urandom_range(0, 31));
      int          gdly = $urandom_range(0, 2);
      int          vdly = $urandom_range(0, 2);
      if (kind <= 1) begin
        applyStimulus(kind == 0 ? OP_ADD : OP_BRANCH, r, x2, sz, sh, un, rd);
        exp_res = r;
        exp_rd  = (kind == 0) ? rd : 5'd0;
        checkOutput("rnd_alu_res", res_MEM, exp_res);
        checkOutput("rnd_alu_rd", 32'(rd_MEM), 32'(exp_rd));
      end else begin
        applyStimulus(kind == 2 ? OP_STORE : OP_LOAD, r, x2, sz, sh, un, rd);
        checkOutput("rnd_addr", dmem_addr, r & ~32'd3);
        checkOutput("rnd_we", 32'(dmem_we), (kind == 2) ? 32'd1 : 32'd0);
        if (kind == 2) begin
          checkOutput("rnd_be", 32'(dmem_be), 32'(model_be(sz, sh)));
          checkOutput("rnd_wdata", dmem_wdata, model_wdata(sz, x2));
        end
        for (int k = 0; k < gdly; k++) cycle();
        dmem_gnt = 1'b1;
        cycle();
        dmem_gnt = 1'b0;
        if (kind == 3) begin
          logic [31:0] rdat = $urandom;
          for (int k = 0; k < vdly; k++) cycle();
          dmem_rvalid = 1'b1; dmem_rdata = rdat;
          cycle();
          dmem_rvalid = 1'b0;
          exp_res = model_load(sz, sh, un, rdat);
          exp_rd  = rd;
        end else begin
          exp_rd = 5'd0;
        end
        checkOutput("rnd_mem_res", res_MEM, exp_res);
        checkOutput("rnd_mem_rd", 32'(rd_MEM), 32'(exp_rd));
        checkOutput("rnd_mem_stall", 32'(stall_req), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
